// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types for the 2:1 AXI4-Lite arbiter.
// Holds the FSM state encoding and default timeout constants.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA
  } arb_state_e;

  localparam int unsigned ARB_TIMEOUT = 1024;
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin pick.
// Ties go to the master not granted last; a lone requester always wins.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);

  // choose winner from request pattern and last-grant pointer
  always_comb begin
    gnt_id_o = 1'b0;
    unique case (1'b1)
      (req_i == 2'b11): gnt_id_o = ~last_i;
      (req_i == 2'b10): gnt_id_o = 1'b1;
      default:          gnt_id_o = 1'b0;
    endcase
    gnt_vld_o = en_i & (|req_i);
  end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// axi4_lite_arbiter_2to1: two AXI4-Lite masters onto one slave port.
// One transaction in flight; stalled phases are force-completed.
module axi4_lite_arbiter_2to1
  import axi_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = ARB_TIMEOUT_DATA
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                m0_awvalid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [2:0]          m0_awprot,
  output logic                m0_awready,
  input  logic                m0_wvalid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_wready,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [2:0]          m0_arprot,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m0_rready,
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [2:0]          m1_awprot,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_wready,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [2:0]          m1_arprot,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  input  logic                m1_rready,
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [2:0]          s_awprot,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wready,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [2:0]          s_arprot,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic                s_rready,
  output logic                grant_id,
  output logic                busy,
  output logic                timeout_err
);

  localparam logic [31:0] TO_LAST = TIMEOUT - 1;

  arb_state_e  state_q;
  logic        grant_q;
  logic        ptr_q;
  logic        aw_done_q;
  logic        w_done_q;
  logic [31:0] cnt_q;
  logic        force_q;
  logic        terr_q;

  logic        arb_gnt;
  logic        arb_vld;
  logic        new_wr;

  logic                g_awvalid;
  logic [ADDR_W-1:0]   g_awaddr;
  logic [2:0]          g_awprot;
  logic                g_wvalid;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;
  logic                g_bready;
  logic                g_arvalid;
  logic [ADDR_W-1:0]   g_araddr;
  logic [2:0]          g_arprot;
  logic                g_rready;

  logic              mo_awready;
  logic              mo_wready;
  logic              mo_bvalid;
  logic              mo_arready;
  logic              mo_rvalid;
  logic [DATA_W-1:0] mo_rdata;

  logic is_busy;
  logic is_wr;
  logic is_rd;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic ar_hs;
  logic r_hs;
  logic hs_any;
  logic aw_d;
  logic w_d;
  logic rsp_hs;
  logic to_hit;

  assign is_busy = (state_q != ST_IDLE);
  assign is_wr   = (state_q == ST_WR_ADDR) ||
                   (state_q == ST_WR_RESP);
  assign is_rd   = (state_q == ST_RD_ADDR) ||
                   (state_q == ST_RD_DATA);

  rr_arbiter_2 u_rr (
    .req_i     ({m1_awvalid | m1_arvalid,
                 m0_awvalid | m0_arvalid}),
    .last_i    (ptr_q),
    .en_i      (state_q == ST_IDLE),
    .gnt_id_o  (arb_gnt),
    .gnt_vld_o (arb_vld)
  );

  assign new_wr = arb_gnt ? m1_awvalid : m0_awvalid;

  // select the granted master's request-side signals
  always_comb begin
    if (grant_q) begin
      g_awvalid = m1_awvalid;
      g_awaddr  = m1_awaddr;
      g_awprot  = m1_awprot;
      g_wvalid  = m1_wvalid;
      g_wdata   = m1_wdata;
      g_wstrb   = m1_wstrb;
      g_bready  = m1_bready;
      g_arvalid = m1_arvalid;
      g_araddr  = m1_araddr;
      g_arprot  = m1_arprot;
      g_rready  = m1_rready;
    end else begin
      g_awvalid = m0_awvalid;
      g_awaddr  = m0_awaddr;
      g_awprot  = m0_awprot;
      g_wvalid  = m0_wvalid;
      g_wdata   = m0_wdata;
      g_wstrb   = m0_wstrb;
      g_bready  = m0_bready;
      g_arvalid = m0_arvalid;
      g_araddr  = m0_araddr;
      g_arprot  = m0_arprot;
      g_rready  = m0_rready;
    end
  end

  // route handshakes per state; forced completion answers the master
  always_comb begin
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    mo_awready = 1'b0;
    mo_wready  = 1'b0;
    mo_bvalid  = 1'b0;
    mo_arready = 1'b0;
    mo_rvalid  = 1'b0;
    mo_rdata   = '0;
    if (force_q) begin
      mo_awready = terr_q & (state_q == ST_WR_ADDR) & ~aw_done_q;
      mo_wready  = terr_q & (state_q == ST_WR_ADDR) & ~w_done_q;
      mo_arready = terr_q & (state_q == ST_RD_ADDR);
      mo_bvalid  = is_wr;
      mo_rvalid  = is_rd;
      mo_rdata   = is_rd ? TIMEOUT_DATA : '0;
    end else begin
      unique case (state_q)
        ST_WR_ADDR: begin
          s_awvalid  = g_awvalid & ~aw_done_q;
          s_wvalid   = g_wvalid & ~w_done_q;
          mo_awready = s_awready & ~aw_done_q;
          mo_wready  = s_wready & ~w_done_q;
        end
        ST_WR_RESP: begin
          s_bready  = g_bready;
          mo_bvalid = s_bvalid;
        end
        ST_RD_ADDR: begin
          s_arvalid  = g_arvalid;
          mo_arready = s_arready;
        end
        ST_RD_DATA: begin
          s_rready  = g_rready;
          mo_rvalid = s_rvalid;
          mo_rdata  = s_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  assign s_awaddr = is_busy ? g_awaddr : '0;
  assign s_awprot = is_busy ? g_awprot : '0;
  assign s_wdata  = is_busy ? g_wdata  : '0;
  assign s_wstrb  = is_busy ? g_wstrb  : '0;
  assign s_araddr = is_busy ? g_araddr : '0;
  assign s_arprot = is_busy ? g_arprot : '0;

  assign m0_awready = ~grant_q & mo_awready;
  assign m0_wready  = ~grant_q & mo_wready;
  assign m0_bvalid  = ~grant_q & mo_bvalid;
  assign m0_arready = ~grant_q & mo_arready;
  assign m0_rvalid  = ~grant_q & mo_rvalid;
  assign m0_rdata   = grant_q ? '0 : mo_rdata;
  assign m1_awready = grant_q & mo_awready;
  assign m1_wready  = grant_q & mo_wready;
  assign m1_bvalid  = grant_q & mo_bvalid;
  assign m1_arready = grant_q & mo_arready;
  assign m1_rvalid  = grant_q & mo_rvalid;
  assign m1_rdata   = grant_q ? mo_rdata : '0;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign b_hs   = s_bvalid & s_bready;
  assign ar_hs  = s_arvalid & s_arready;
  assign r_hs   = s_rvalid & s_rready;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign aw_d   = aw_done_q | aw_hs;
  assign w_d    = w_done_q | w_hs;
  assign rsp_hs = (mo_bvalid & g_bready) |
                  (mo_rvalid & g_rready);
  assign to_hit = (TIMEOUT != 0) && !hs_any &&
                  (cnt_q == TO_LAST);

  // arbitration, transaction sequencing and stall timeout
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      ptr_q     <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      terr_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        cnt_q <= '0;
        if (arb_vld) begin
          grant_q <= arb_gnt;
          ptr_q   <= arb_gnt;
          state_q <= new_wr ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end else if (force_q) begin
        if (rsp_hs) begin
          state_q   <= ST_IDLE;
          force_q   <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          cnt_q     <= '0;
        end
      end else if (to_hit) begin
        force_q <= 1'b1;
        terr_q  <= 1'b1;
      end else begin
        cnt_q <= hs_any ? '0 : cnt_q + 32'd1;
        unique case (state_q)
          ST_WR_ADDR: begin
            if (aw_d && w_d) begin
              state_q   <= ST_WR_RESP;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              aw_done_q <= aw_d;
              w_done_q  <= w_d;
            end
          end
          ST_WR_RESP: if (b_hs)  state_q <= ST_IDLE;
          ST_RD_ADDR: if (ar_hs) state_q <= ST_RD_DATA;
          ST_RD_DATA: if (r_hs)  state_q <= ST_IDLE;
          default:               state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign grant_id    = grant_q;
  assign busy        = is_busy;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// tb_axi4_lite_arbiter_2to1: directed vectors for the 2:1 arbiter.
// Cycle table plus hand sequences for late W, timeout and reset.
module tb_axi4_lite_arbiter_2to1;

  localparam logic [31:0] A0W = 32'h0000_1000;
  localparam logic [31:0] A0R = 32'h0000_2000;
  localparam logic [31:0] A1W = 32'h0000_3000;
  localparam logic [31:0] A1R = 32'h0000_4000;
  localparam logic [31:0] D0  = 32'h1234_5678;
  localparam logic [31:0] D1  = 32'h9ABC_DEF0;
  localparam logic [31:0] RD  = 32'h5555_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready;
  logic        m0_bvalid, m0_bready, m0_arvalid, m0_arready;
  logic        m0_rvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_araddr, m0_wdata, m0_rdata;
  logic [2:0]  m0_awprot, m0_arprot;
  logic [3:0]  m0_wstrb;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready;
  logic        m1_bvalid, m1_bready, m1_arvalid, m1_arready;
  logic        m1_rvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_araddr, m1_wdata, m1_rdata;
  logic [2:0]  m1_awprot, m1_arprot;
  logic [3:0]  m1_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic        s_bvalid, s_bready, s_arvalid, s_arready;
  logic        s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic        grant_id, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_lite_arbiter_2to1 #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(16),
    .TIMEOUT_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr),
    .m0_awprot(m0_awprot), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr),
    .m0_arprot(m0_arprot), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr),
    .m1_awprot(m1_awprot), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr),
    .m1_arprot(m1_arprot), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr),
    .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr),
    .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .s_rready(s_rready),
    .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err)
  );

  typedef struct {
    string      name;
    logic [1:0] aw;
    logic [1:0] ar;
    logic [4:0] sin;
    logic [8:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string n, input logic [1:0] aw,
                     input logic [1:0] ar, input logic [4:0] sin,
                     input logic [8:0] exp);
    vec_t v;
    v.name = n;
    v.aw   = aw;
    v.ar   = ar;
    v.sin  = sin;
    v.exp  = exp;
    tv.push_back(v);
  endtask

  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  task automatic chk9(input string n, input logic [8:0] a,
                      input logic [8:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b want %b", n, a, e);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a,
                       input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  task automatic drive(input logic [1:0] aw, input logic [1:0] ar,
                       input logic [4:0] sin);
    m0_awvalid = aw[0];
    m0_wvalid  = aw[0];
    m1_awvalid = aw[1];
    m1_wvalid  = aw[1];
    m0_arvalid = ar[0];
    m1_arvalid = ar[1];
    {s_rvalid, s_arready, s_bvalid, s_wready, s_awready} = sin;
  endtask

  function automatic logic [8:0] obs();
    return {busy, grant_id, s_awvalid, s_wvalid, s_arvalid,
            m0_bvalid, m1_bvalid, m0_rvalid, m1_rvalid};
  endfunction

  initial begin
    // exp: busy gid s_aw s_w s_ar b0 b1 r0 r1
    // sin: rvalid arready bvalid wready awready
    add("rst_idle", 2'b00, 2'b00, 5'b00000, 9'b0_0_000_0000);
    add("tie_idle", 2'b00, 2'b11, 5'b00000, 9'b0_0_000_0000);
    add("m0_ar",    2'b00, 2'b11, 5'b01000, 9'b1_0_001_0000);
    add("m0_r",     2'b00, 2'b10, 5'b10000, 9'b1_0_000_0010);
    add("gap1",     2'b00, 2'b10, 5'b00000, 9'b0_0_000_0000);
    add("m1_ar",    2'b00, 2'b10, 5'b01000, 9'b1_1_001_0000);
    add("m1_r",     2'b00, 2'b00, 5'b10000, 9'b1_1_000_0001);
    add("gap2",     2'b00, 2'b00, 5'b00000, 9'b0_1_000_0000);
    add("wr_req",   2'b01, 2'b00, 5'b00000, 9'b0_1_000_0000);
    add("wr_aw",    2'b01, 2'b00, 5'b00011, 9'b1_0_110_0000);
    add("wr_bwait", 2'b00, 2'b00, 5'b00000, 9'b1_0_000_0000);
    add("wr_b",     2'b00, 2'b00, 5'b00100, 9'b1_0_000_1000);
    add("gap3",     2'b00, 2'b00, 5'b00000, 9'b0_0_000_0000);
    add("tie2",     2'b00, 2'b11, 5'b00000, 9'b0_0_000_0000);
    add("m1_ar2",   2'b00, 2'b11, 5'b01000, 9'b1_1_001_0000);
    add("m1_r2",    2'b00, 2'b01, 5'b10000, 9'b1_1_000_0001);
    add("gap4",     2'b00, 2'b01, 5'b00000, 9'b0_1_000_0000);
    add("m0_ar2",   2'b00, 2'b01, 5'b01000, 9'b1_0_001_0000);
    add("m0_r2",    2'b00, 2'b00, 5'b10000, 9'b1_0_000_0010);
    add("gap5",     2'b00, 2'b00, 5'b00000, 9'b0_0_000_0000);

    resetn    = 1'b0;
    m0_awaddr = A0W; m0_araddr = A0R; m0_wdata = D0;
    m1_awaddr = A1W; m1_araddr = A1R; m1_wdata = D1;
    m0_awprot = 3'd0; m0_arprot = 3'd0; m0_wstrb = 4'hF;
    m1_awprot = 3'd0; m1_arprot = 3'd0; m1_wstrb = 4'hF;
    m0_bready = 1'b1; m0_rready = 1'b1;
    m1_bready = 1'b1; m1_rready = 1'b1;
    s_rdata   = RD;
    drive(2'b00, 2'b00, 5'b00000);
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_gid", grant_id, 1'b0);
    chk1("rst_err", timeout_err, 1'b0);
    resetn = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].aw, tv[i].ar, tv[i].sin);
      #1;
      chk9(tv[i].name, obs(), tv[i].exp);
      if (tv[i].exp[6])
        chk32({tv[i].name, "_awaddr"}, s_awaddr,
              tv[i].exp[7] ? A1W : A0W);
      if (tv[i].exp[5])
        chk32({tv[i].name, "_wdata"}, s_wdata,
              tv[i].exp[7] ? D1 : D0);
      if (tv[i].exp[4])
        chk32({tv[i].name, "_araddr"}, s_araddr,
              tv[i].exp[7] ? A1R : A0R);
      if (tv[i].exp[1])
        chk32({tv[i].name, "_m0rdata"}, m0_rdata, RD);
      if (tv[i].exp[0])
        chk32({tv[i].name, "_m1rdata"}, m1_rdata, RD);
    end

    // m1 write+read together, W three cycles after AW
    @(negedge clk);
    drive(2'b00, 2'b00, 5'b00011);
    m1_awvalid = 1'b1; m1_arvalid = 1'b1;
    #1 chk1("c0_busy", busy, 1'b0);
    @(negedge clk); #1;
    chk1("c1_awv", s_awvalid, 1'b1);
    chk1("c1_wv", s_wvalid, 1'b0);
    chk1("c1_gid", grant_id, 1'b1);
    chk32("c1_awaddr", s_awaddr, A1W);
    @(negedge clk);
    m1_awvalid = 1'b0; s_bvalid = 1'b1;
    #1;
    chk1("c2_awv", s_awvalid, 1'b0);
    chk1("c2_b", m1_bvalid, 1'b0);
    chk1("c2_busy", busy, 1'b1);
    @(negedge clk); #1;
    chk1("c3_b", m1_bvalid, 1'b0);
    chk1("c3_wv", s_wvalid, 1'b0);
    @(negedge clk);
    m1_wvalid = 1'b1;
    #1;
    chk1("c4_wv", s_wvalid, 1'b1);
    chk32("c4_wdata", s_wdata, D1);
    chk1("c4_b", m1_bvalid, 1'b0);
    chk1("c4_arv", s_arvalid, 1'b0);
    @(negedge clk);
    m1_wvalid = 1'b0;
    #1;
    chk1("c5_b", m1_bvalid, 1'b1);
    chk1("c5_arv", s_arvalid, 1'b0);
    @(negedge clk);
    s_bvalid = 1'b0;
    #1 chk1("c6_busy", busy, 1'b0);
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    chk1("c7_arv", s_arvalid, 1'b1);
    chk32("c7_araddr", s_araddr, A1R);
    chk1("c7_gid", grant_id, 1'b1);
    @(negedge clk);
    m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1;
    #1;
    chk1("c8_rv", m1_rvalid, 1'b1);
    chk32("c8_rdata", m1_rdata, RD);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1 chk1("c9_busy", busy, 1'b0);

    // m1 read with slave never returning rvalid
    @(negedge clk);
    drive(2'b00, 2'b10, 5'b00000);
    #1 chk1("t0_busy", busy, 1'b0);
    @(negedge clk);
    s_arready = 1'b1;
    #1 chk1("t1_arv", s_arvalid, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      m1_arvalid = 1'b0; s_arready = 1'b0;
      #1;
      chk1("t_wait_rv", m1_rvalid, 1'b0);
      chk1("t_wait_err", timeout_err, 1'b0);
      chk1("t_wait_busy", busy, 1'b1);
    end
    @(negedge clk); #1;
    chk1("t_rv", m1_rvalid, 1'b1);
    chk32("t_rdata", m1_rdata, 32'hDEAD_BEEF);
    chk1("t_err", timeout_err, 1'b1);
    chk1("t_srready", s_rready, 1'b0);
    @(negedge clk); #1;
    chk1("t_err_off", timeout_err, 1'b0);
    chk1("t_idle", busy, 1'b0);
    chk1("t_rv_off", m1_rvalid, 1'b0);

    // reset while m0 write sits in the response phase
    @(negedge clk);
    drive(2'b01, 2'b00, 5'b00011);
    #1 chk1("r0_busy", busy, 1'b0);
    @(negedge clk); #1;
    chk1("r1_awv", s_awvalid, 1'b1);
    @(negedge clk);
    drive(2'b00, 2'b01, 5'b00100);
    #1 chk1("r2_b", m0_bvalid, 1'b1);
    resetn = 1'b0;
    #1;
    chk1("r2_rst_b", m0_bvalid, 1'b0);
    chk1("r2_rst_busy", busy, 1'b0);
    chk1("r2_rst_sbr", s_bready, 1'b0);
    chk1("r2_rst_gid", grant_id, 1'b0);
    @(negedge clk); #1;
    chk1("r3_busy", busy, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk1("r4_busy", busy, 1'b0);
    chk1("r4_b", m0_bvalid, 1'b0);
    @(negedge clk);
    s_arready = 1'b1;
    #1;
    chk1("r5_busy", busy, 1'b1);
    chk1("r5_gid", grant_id, 1'b0);
    chk1("r5_arv", s_arvalid, 1'b1);
    chk1("r5_b", m0_bvalid, 1'b0);
    @(negedge clk);
    drive(2'b00, 2'b00, 5'b10000);
    #1 chk1("r6_rv", m0_rvalid, 1'b1);
    @(negedge clk);
    drive(2'b00, 2'b00, 5'b00000);
    #1 chk1("r7_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_arbiter_2to1.md
AXI4_LITE_ARBITER_2TO1 -- requirements
Module: axi4_lite_arbiter_2to1

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all aw/ar addr ports.
REQ-002 Parameter DATA_W, default 32, width of wdata/rdata; wstrb width is DATA_W/8.
REQ-003 Parameter TIMEOUT, default 1024, cycles the slave may stall one phase before forced completion; 0 disables.
REQ-004 Parameter TIMEOUT_DATA, default 32'hDEAD_BEEF, rdata returned on a timed-out read.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 resetn  input  1  reset, asynchronous assert, active-low.
REQ-007 m0_aw{valid,addr,prot} input 1/ADDR_W/3, m0_awready output 1: master 0 (CPU) write address.
REQ-008 m0_w{valid,data,strb} input 1/DATA_W/DATA_W/8, m0_wready output 1: master 0 write data.
REQ-009 m0_bvalid output 1, m0_bready input 1: master 0 write response.
REQ-010 m0_ar{valid,addr,prot} input 1/ADDR_W/3, m0_arready output 1: master 0 read address.
REQ-011 m0_r{valid,data} output 1/DATA_W, m0_rready input 1: master 0 read data.
REQ-012 m1_* ports identical to REQ-007..011: master 1 (accelerator DMA).
REQ-013 s_* ports, mirror direction of REQ-007..011: single downstream port to the slave decoder.
REQ-014 grant_id output 1: master owning the current transaction; busy output 1: state not IDLE.
REQ-015 timeout_err output 1: one-cycle pulse when a transaction is force-completed.

Function
REQ-016 States: IDLE, WR_ADDR (AW/W phase), WR_RESP, RD_ADDR, RD_DATA; one transaction in flight at a time.
REQ-017 Request of master N = mN_awvalid | mN_arvalid; if both are set, the write is served first.
REQ-018 In IDLE, registered arbitration: on any request, grant_id and next state are latched at that edge; forwarding starts the following cycle (1-cycle arbitration latency).
REQ-019 Round-robin: on simultaneous requests, grant the master not granted last; last-grant pointer resets to 1 so master 0 wins the first tie.
REQ-020 A lone requester is granted regardless of pointer; pointer updates only on grant.
REQ-021 Granted master's channels are connected combinationally to s_*; non-granted master sees all ready/valid outputs 0, data outputs 0.
REQ-022 WR_ADDR: AW and W forwarded independently; sticky aw_done/w_done flags block re-forwarding after each handshake; both done -> WR_RESP.
REQ-023 WR_RESP: bvalid/bready forwarded; handshake -> IDLE.
REQ-024 RD_ADDR: arvalid/arready forwarded; handshake -> RD_DATA; RD_DATA: r forwarded; handshake -> IDLE.
REQ-025 A new grant is never issued in the cycle the previous transaction completes; minimum one IDLE cycle between transactions.
REQ-026 Timeout counter clears on every state entry and every handshake; reaching TIMEOUT in a non-IDLE state: grant's outstanding handshakes completed toward the master (readies 1, bvalid or rvalid 1 with rdata=TIMEOUT_DATA) for one cycle with s_* valids driven 0, timeout_err pulses, state -> IDLE only after the master's bready/rready handshake.
REQ-027 Master-side valid deassertion before handshake (protocol violation) is not detected; behaviour then undefined.

Reset
REQ-028 resetn low: state IDLE, grant_id 0, busy 0, pointer 1, done flags 0, counter 0, timeout_err 0, all ready/valid outputs 0 -- immediately, without clock.
REQ-029 Reset mid-transaction abandons it; no response is issued after release; first post-reset grant follows REQ-018.

Structure
REQ-030 Shared package axi_arb_pkg holds the state enum and default TIMEOUT/TIMEOUT_DATA constants.
REQ-031 One sub-module rr_arbiter_2: requests, pointer, grant-enable -> grant; all other logic in the top.

Verification
REQ-032 m0 write addr 0x1000 data 0x12345678 alone -> s_awaddr 0x1000 one cycle after request, m0_bvalid after s_bvalid, grant_id 0.
REQ-033 m0 and m1 reads same cycle after reset -> m0 served first, then m1; repeat -> m1 then m0 order alternates correctly.
REQ-034 m1 awvalid and arvalid together, W arrives 3 cycles after AW -> write completes first, WR_RESP entered only after W handshake, then read.
REQ-035 Slave withholds rvalid, TIMEOUT=16 -> 16 cycles in RD_DATA, m1_rdata 0xDEADBEEF with rvalid, timeout_err 1-cycle pulse, then IDLE.
REQ-036 resetn low during WR_RESP -> all outputs 0 same cycle, busy 0; after release pending m0 read granted with 1-cycle latency.
